// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result and flags.
// Single-cycle ops complete one clock after accept. Defining ALU_SEQ_MUL_EN
// compiles in an iterative shift-add multiplier (opcode 12, WIDTH clocks);
// without it opcode 12 is reported as illegal like 13-15.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [3:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             err
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_SUB = 4'd1,  OP_NOT = 4'd2,  OP_AND = 4'd3,
      OP_OR   = 4'd4,  OP_XOR = 4'd5,  OP_SLT = 4'd6,  OP_EQ  = 4'd7,
      OP_SLL  = 4'd8,  OP_SRL = 4'd9,  OP_SRA = 4'd10, OP_SLTU = 4'd11,
      OP_MUL  = 4'd12
   } op_e;

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
`else
   typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_e;
`endif

   state_e           state, state_next, start_state;
   logic             accept;

   logic [WIDTH-1:0] alu_out;
   logic             alu_carry, alu_ovf, alu_err;
   logic [WIDTH:0]   sum, diff;
   logic [SHW-1:0]   sh;

`ifdef ALU_SEQ_MUL_EN
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
   logic                 is_mul;
   logic [2*WIDTH-1:0]   acc, acc_next, mcand;
   logic [WIDTH-1:0]     mplier;
   logic [SHW-1:0]       cnt;
`endif

   // Single-cycle datapath: result and flags for the opcode on the inputs.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case leaves it unassigned, which would infer a latch.
      alu_out   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      alu_err   = 1'b0;
      sh        = op2[SHW-1:0];
      sum       = {1'b0, op1} + {1'b0, op2};
      diff      = {1'b0, op1} + {1'b0, ~op2} + {{WIDTH{1'b0}}, 1'b1};
      case (opcode)
         OP_ADD: begin
            alu_out   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
            alu_ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) & (sum[WIDTH-1] != op1[WIDTH-1]);
         end
         OP_SUB: begin
            alu_out   = diff[WIDTH-1:0];
            alu_carry = diff[WIDTH];
            alu_ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) & (diff[WIDTH-1] != op1[WIDTH-1]);
         end
         OP_NOT:  alu_out = ~op1;
         OP_AND:  alu_out = op1 & op2;
         OP_OR:   alu_out = op1 | op2;
         OP_XOR:  alu_out = op1 ^ op2;
         OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
         OP_EQ:   alu_out = {{(WIDTH-1){1'b0}}, op1 == op2};
         OP_SLL:  alu_out = op1 << sh;
         OP_SRL:  alu_out = op1 >> sh;
         OP_SRA:  alu_out = $unsigned($signed(op1) >>> sh);
         OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, op1 < op2};
         // Opcodes 13-15, and 12 when no multiplier is built.
         default: alu_err = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   // Multiplier step: add the shifted multiplicand when the current op2 bit is set.
   always_comb begin
      is_mul   = (opcode == OP_MUL);
      acc_next = acc + (mplier[0] ? mcand : '0);
   end
`endif

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of block ordering.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Handshake decode and next-state logic.
   always_comb begin
      state_next = state;
      in_ready   = (state == IDLE) | ((state == DONE) & out_ready);
      out_valid  = (state == DONE);
      accept     = in_valid & in_ready;
`ifdef ALU_SEQ_MUL_EN
      start_state = is_mul ? BUSY : DONE;
`else
      start_state = DONE;
`endif
      case (state)
         IDLE: if (accept) state_next = start_state;
`ifdef ALU_SEQ_MUL_EN
         BUSY: if (cnt == LAST) state_next = DONE;
`endif
         DONE: begin
            if (accept)         state_next = start_state;
            else if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Result/flag registers and multiplier iteration; outputs only change on
   // accept or multiply completion, so they hold while the sink stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out      <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         err      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
`endif
      end else if (accept) begin
`ifdef ALU_SEQ_MUL_EN
         if (is_mul) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, op1};
            mplier <= op2;
            cnt    <= '0;
         end else
`endif
         begin
            out      <= alu_out;
            carry    <= alu_carry;
            overflow <= alu_ovf;
            zero     <= (alu_out == '0);
            err      <= alu_err;
         end
      end
`ifdef ALU_SEQ_MUL_EN
      else if (state == BUSY) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (cnt == LAST) begin
            out      <= acc_next[WIDTH-1:0];
            carry    <= |acc_next[2*WIDTH-1:WIDTH];
            overflow <= 1'b0;
            zero     <= (acc_next[WIDTH-1:0] == '0);
            err      <= 1'b0;
         end
      end
`endif
   end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8). A reference model computes each result
// with plain integer arithmetic; a negedge process compares every presented
// result, its latency, and its stability under backpressure. Directed
// vectors carry hand-computed values that pin both the model and the DUT.
module tb_alu_seq;

   localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready;
   logic         carry, overflow, zero, err;
   logic [W-1:0] op1, op2, out;
   logic [3:0]   opcode;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op1(op1), .op2(op2), .opcode(opcode), .out_valid(out_valid),
      .out_ready(out_ready), .out(out), .carry(carry), .overflow(overflow),
      .zero(zero), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct { logic [W-1:0] out; logic [3:0] flags; } res_t;  // flags = {carry,overflow,zero,err}
   typedef struct { res_t r; int due; } pend_t;

   pend_t q[$];
   bit    front_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference behaviour in integer arithmetic.
   function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t r;
      int ua, ub, sa, sb, s, sh;
      logic c, v, e;
      ua = a; ub = b;
      sa = $signed(a); sb = $signed(b);
      sh = ub % W;
      r.out = '0; c = 0; v = 0; e = 0; s = 0;
      case (op)
         0: begin s = ua + ub; r.out = s[W-1:0]; c = (s >= (1 << W));
                  s = sa + sb; v = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1))); end
         1: begin s = ua - ub; r.out = s[W-1:0]; c = (ua >= ub);
                  s = sa - sb; v = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1))); end
         2: r.out = ~a;
         3: r.out = a & b;
         4: r.out = a | b;
         5: r.out = a ^ b;
         6: r.out = (sa < sb) ? 1 : 0;
         7: r.out = (ua == ub) ? 1 : 0;
         8: begin s = ua << sh; r.out = s[W-1:0]; end
         9: begin s = ua >> sh; r.out = s[W-1:0]; end
         10: begin s = sa >>> sh; r.out = s[W-1:0]; end
         11: r.out = (ua < ub) ? 1 : 0;
         12: begin
            if (MUL_EN) begin s = ua * ub; r.out = s[W-1:0]; c = (s >= (1 << W)); end
            else e = 1;
         end
         default: e = 1;
      endcase
      r.flags = {c, v, (r.out == 0), e};
      return r;
   endfunction

   // Compare process: checks every presented result against the model.
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         front_seen = 1'b0;
      end else begin
         if (q.size() > 0) begin
            if (out_valid) begin
               if (!front_seen) begin
                  check("latency", cyc, q[0].due);
                  front_seen = 1'b1;
               end
               check("out", out, q[0].r.out);
               check("flags", {carry, overflow, zero, err}, q[0].r.flags);
               if (out_ready) begin
                  void'(q.pop_front());
                  front_seen = 1'b0;
               end
            end else if (cyc >= q[0].due) begin
               check("valid_timeout", out_valid, 1);
               void'(q.pop_front());
               front_seen = 1'b0;
            end
         end else begin
            check("no_spurious_valid", out_valid, 0);
         end
         if (in_valid && in_ready) begin
            pend_t p;
            p.r   = model(opcode, op1, op2);
            p.due = cyc + 1 + (((opcode == 4'd12) && MUL_EN) ? W : 0);
            q.push_back(p);
         end
      end
   end

   // Present an operation and hold it until accepted; n = cycles taken.
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int n);
      logic got;
      got = 1'b0;
      n   = 0;
      in_valid = 1'b1; opcode = op; op1 = a; op2 = b;
      while (!got && n < 40) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      check("accept", got, 1);
      // Scramble inputs so a design that fails to capture at accept is exposed.
      in_valid = 1'b0; op1 = ~a; op2 = ~b; opcode = 4'd15;
   endtask

   task automatic expect_now(input string name, input logic [W-1:0] exp_out, input logic [3:0] exp_flags);
      @(negedge clk);
      check({name, "_valid"}, out_valid, 1);
      check({name, "_out"}, out, exp_out);
      check({name, "_flags"}, {carry, overflow, zero, err}, exp_flags);
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_out, input logic [3:0] exp_flags);
      res_t m;
      int   n;
      m = model(op, a, b);
      check({name, "_model_out"}, m.out, exp_out);
      check({name, "_model_flags"}, m.flags, exp_flags);
      send(op, a, b, n);
      expect_now(name, exp_out, exp_flags);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, want finish before 100000 ns");
      $fatal(1);
   end

   initial begin
      int n, total;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op1 = '0; op2 = '0; opcode = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out", out, 0);
      check("rst_flags", {carry, overflow, zero, err}, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed vectors; flags are {carry,overflow,zero,err}.
      run_vec("add_ovf",   4'd0,  8'h7F, 8'h01, 8'h80, 4'b0100);
      run_vec("add_carry", 4'd0,  8'hFF, 8'h01, 8'h00, 4'b1010);
      run_vec("sub_borrow",4'd1,  8'h00, 8'h01, 8'hFF, 4'b0000);
      run_vec("sub_ovf",   4'd1,  8'h80, 8'h01, 8'h7F, 4'b1100);
      run_vec("sub_equal", 4'd1,  8'h05, 8'h05, 8'h00, 4'b1010);
      run_vec("not",       4'd2,  8'h0F, 8'h33, 8'hF0, 4'b0000);
      run_vec("and",       4'd3,  8'hCC, 8'hAA, 8'h88, 4'b0000);
      run_vec("or",        4'd4,  8'hF0, 8'h0F, 8'hFF, 4'b0000);
      run_vec("xor",       4'd5,  8'h3C, 8'h3C, 8'h00, 4'b0010);
      run_vec("slt",       4'd6,  8'hFF, 8'h01, 8'h01, 4'b0000);
      run_vec("eq",        4'd7,  8'h5A, 8'h5A, 8'h01, 4'b0000);
      run_vec("sll",       4'd8,  8'h81, 8'h09, 8'h02, 4'b0000);
      run_vec("srl",       4'd9,  8'h80, 8'h03, 8'h10, 4'b0000);
      run_vec("sra",       4'd10, 8'h80, 8'h0B, 8'hF0, 4'b0000);
      run_vec("sltu",      4'd11, 8'hFF, 8'h01, 8'h00, 4'b0010);
      run_vec("illegal14", 4'd14, 8'h12, 8'h34, 8'h00, 4'b0011);
      run_vec("illegal15", 4'd15, 8'hFF, 8'hFF, 8'h00, 4'b0011);

      // Back-to-back: four ops with out_ready high take one cycle each.
      total = 0;
      send(4'd0, 8'h01, 8'h02, n); total += n;
      send(4'd1, 8'h09, 8'h04, n); total += n;
      send(4'd5, 8'hA5, 8'h0F, n); total += n;
      send(4'd4, 8'h10, 8'h01, n); total += n;
      check("b2b_cycles", total, 4);
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: AND result held for 5 cycles, then released while a new op is accepted.
      send(4'd3, 8'hCC, 8'hAA, n);
      out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("bp_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_out", out, 8'h88);
         check("bp_flags", {carry, overflow, zero, err}, 4'b0000);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(4'd5, 8'h0F, 8'hFF, n);
      check("bp_same_cycle_accept", n, 1);
      expect_now("bp_next", 8'hF0, 4'b0000);

`ifdef ALU_SEQ_MUL_EN
      check("mul1_model_out", model(4'd12, 8'h0F, 8'h11).out, 8'hFF);
      send(4'd12, 8'h0F, 8'h11, n);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         check("mul_busy_in_ready", in_ready, 0);
         check("mul_busy_valid", out_valid, 0);
      end
      expect_now("mul1", 8'hFF, 4'b0000);
      check("mul2_model_flags", model(4'd12, 8'h10, 8'h10).flags, 4'b1010);
      send(4'd12, 8'h10, 8'h10, n);
      repeat (W) @(negedge clk);
      expect_now("mul2", 8'h00, 4'b1010);
`else
      run_vec("mul_illegal", 4'd12, 8'h0F, 8'h11, 8'h00, 4'b0011);
`endif

      // Reset during the 4th cycle of a multiply; the aborted result must never appear.
      send(4'd12, 8'h03, 8'h05, n);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_out", out, 0);
      check("abort_flags", {carry, overflow, zero, err}, 0);
      @(posedge clk);
      #1;
      run_vec("post_abort_add", 4'd0, 8'h02, 8'h03, 8'h05, 4'b0000);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
